// File: rtl/enemy_hit_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_hit_ctrl
//
// Purpose:
//   Contact and life-cycle controller for one enemy. Each 10 Hz game tick it
//   compares the player hitbox with the enemy hitbox and sorts any contact
//   into one of two kinds:
//     - a stomp, where the player lands on the enemy's top: the enemy is
//       squashed and the player bounces;
//     - a side hit, which kills the player.
//   It also steps the enemy through GRACE -> ALIVE -> SQUASH -> GONE and
//   then back to GRACE on respawn.
//
// Ports:
//   clk_10Hz      in   game tick clock
//   RST_N         in   asynchronous active-low reset
//   char_X/Y      in   player left/top edge, screen coords (10 bit)
//   char_falling  in   player vertical velocity is downward
//   enemy_x/y     in   enemy left/top edge, screen coords (10 bit)
//   enemy_en      in   enemy active; contact detection is masked when low
//   enemy_alive   out  state is GRACE or ALIVE
//   enemy_visible out  state is GRACE, ALIVE or SQUASH
//   enemy_squash  out  state is SQUASH (renderer shows the flat sprite)
//   bounce_req    out  one-tick pulse on a stomp
//   player_dead   out  sticky; set by a side hit while ALIVE
//   stomp_count   out  saturating stomp counter
//   state_o       out  GRACE=0, ALIVE=1, SQUASH=2, GONE=3
// ---------------------------------------------------------------------------
module enemy_hit_ctrl #(
  parameter int CHAR_W        = 12,
  parameter int CHAR_H        = 16,
  parameter int ENEMY_W       = 12,
  parameter int ENEMY_H       = 12,
  parameter int STOMP_MARGIN  = 4,
  parameter int GRACE_TICKS   = 10,
  parameter int SQUASH_TICKS  = 5,
  parameter int RESPAWN_TICKS = 30
) (
  input  logic       clk_10Hz,
  input  logic       RST_N,
  input  logic [9:0] char_X,
  input  logic [9:0] char_Y,
  input  logic       char_falling,
  input  logic [9:0] enemy_x,
  input  logic [9:0] enemy_y,
  input  logic       enemy_en,
  output logic       enemy_alive,
  output logic       enemy_visible,
  output logic       enemy_squash,
  output logic       bounce_req,
  output logic       player_dead,
  output logic [7:0] stomp_count,
  output logic [1:0] state_o
);

  localparam logic [1:0] ST_GRACE  = 2'd0;
  localparam logic [1:0] ST_ALIVE  = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;
  localparam logic [1:0] ST_GONE   = 2'd3;

  // The tick counter is 8 bits and every timeout is compared against TICKS-1,
  // so each tick count must lie in 1..255. RESPAWN_TICKS may also be 0, which
  // means the enemy never comes back.
  if (GRACE_TICKS < 1 || GRACE_TICKS > 255 ||
      SQUASH_TICKS < 1 || SQUASH_TICKS > 255 ||
      RESPAWN_TICKS < 0 || RESPAWN_TICKS > 255) begin : g_bad_ticks
    $error("enemy_hit_ctrl: tick parameters out of range");
  end

  localparam logic [10:0] CW = 11'(CHAR_W);
  localparam logic [10:0] CH = 11'(CHAR_H);
  localparam logic [10:0] EW = 11'(ENEMY_W);
  localparam logic [10:0] EH = 11'(ENEMY_H);
  localparam logic [10:0] SM = 11'(STOMP_MARGIN);

  localparam logic [7:0] GRACE_LAST   = 8'(GRACE_TICKS - 1);
  localparam logic [7:0] SQUASH_LAST  = 8'(SQUASH_TICKS - 1);
  localparam logic [7:0] RESPAWN_LAST = 8'(RESPAWN_TICKS - 1);

  logic [1:0] state;
  logic [7:0] cnt;

  // Zero-extend to 11 bits so that position+size cannot wrap. An enemy that
  // has wrapped to the right edge therefore never appears to touch a player
  // at the left edge.
  logic [10:0] cx, cy, ex, ey;
  assign cx = {1'b0, char_X};
  assign cy = {1'b0, char_Y};
  assign ex = {1'b0, enemy_x};
  assign ey = {1'b0, enemy_y};

  logic overlap, stomp_geo, contact_en, stomp_hit, side_hit;

  // Strict '>' on both sides: boxes that only touch along an edge do not overlap.
  assign overlap = (cx + CW > ex) && (ex + EW > cx) &&
                   (cy + CH > ey) && (ey + EH > cy);

  // A stomp requires the player's feet to be no deeper than STOMP_MARGIN
  // below the enemy's top while the player is moving down.
  assign stomp_geo  = overlap && char_falling && (cy + CH <= ey + SM);

  assign contact_en = enemy_en && !player_dead &&
                      (state == ST_GRACE || state == ST_ALIVE);
  assign stomp_hit  = contact_en && stomp_geo;
  assign side_hit   = contact_en && overlap && !stomp_geo;

  // NOTE: all state below updates with non-blocking assignments, so every
  // branch reads the values from before this edge and the order of the
  // statements does not matter.
  always_ff @(posedge clk_10Hz or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_GRACE;
      cnt         <= 8'd0;
      player_dead <= 1'b0;
      bounce_req  <= 1'b0;
      stomp_count <= 8'd0;
    end else begin
      bounce_req <= stomp_hit;
      if (stomp_hit && stomp_count != 8'hFF)
        stomp_count <= stomp_count + 8'd1;

      unique case (state)
        ST_GRACE: begin
          // Side hits are ignored during spawn grace.
          if (stomp_hit) begin
            state <= ST_SQUASH;
            cnt   <= 8'd0;
          end else if (cnt == GRACE_LAST) begin
            state <= ST_ALIVE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_ALIVE: begin
          if (stomp_hit) begin
            state <= ST_SQUASH;
            cnt   <= 8'd0;
          end else if (side_hit) begin
            player_dead <= 1'b1;
          end
        end
        ST_SQUASH: begin
          if (cnt == SQUASH_LAST) begin
            state <= ST_GONE;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_GONE: begin
          if (RESPAWN_TICKS != 0) begin
            if (cnt == RESPAWN_LAST) begin
              state <= ST_GRACE;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        default: begin
          state <= ST_GRACE;
          cnt   <= 8'd0;
        end
      endcase
    end
  end

  // These outputs decode the state register directly, so they change only on
  // a clock edge or on reset.
  assign state_o       = state;
  assign enemy_alive   = (state == ST_GRACE) || (state == ST_ALIVE);
  assign enemy_visible = (state != ST_GONE);
  assign enemy_squash  = (state == ST_SQUASH);

endmodule

// File: tb/tb_enemy_hit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enemy_hit_ctrl
//
// Directed bench for enemy_hit_ctrl with the default parameters
// (GRACE=10, SQUASH=5, RESPAWN=30 ticks). Inputs change 1 time unit after a
// rising edge, and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_enemy_hit_ctrl;

  logic       clk_10Hz = 1'b0;
  logic       RST_N    = 1'b0;
  logic [9:0] char_X, char_Y, enemy_x, enemy_y;
  logic       char_falling, enemy_en;
  logic       enemy_alive, enemy_visible, enemy_squash, bounce_req, player_dead;
  logic [7:0] stomp_count;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  enemy_hit_ctrl dut (
    .clk_10Hz     (clk_10Hz),
    .RST_N        (RST_N),
    .char_X       (char_X),
    .char_Y       (char_Y),
    .char_falling (char_falling),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .enemy_en     (enemy_en),
    .enemy_alive  (enemy_alive),
    .enemy_visible(enemy_visible),
    .enemy_squash (enemy_squash),
    .bounce_req   (bounce_req),
    .player_dead  (player_dead),
    .stomp_count  (stomp_count),
    .state_o      (state_o)
  );

  always #50 clk_10Hz = ~clk_10Hz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_10Hz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_char(input int x, input int y, input logic fall);
    char_X       = 10'(x);
    char_Y       = 10'(y);
    char_falling = fall;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    RST_N = 1'b0;
    #5;
    RST_N = 1'b1;
  endtask

  int bounces;

  initial begin
    enemy_x  = 10'd100;
    enemy_y  = 10'd366;
    enemy_en = 1'b1;
    set_char(500, 100, 1'b0);

    // ---- Reset state -------------------------------------------------------
    #20;
    check("rst_state",   state_o, 0);
    check("rst_alive",   enemy_alive, 1);
    check("rst_visible", enemy_visible, 1);
    check("rst_squash",  enemy_squash, 0);
    check("rst_bounce",  bounce_req, 0);
    check("rst_dead",    player_dead, 0);
    check("rst_count",   stomp_count, 0);
    RST_N = 1'b1;

    // ---- Side-hit geometry during grace is ignored -------------------------
    set_char(90, 366, 1'b0);
    ticks(9);
    check("grace9_state", state_o, 0);
    check("grace9_dead",  player_dead, 0);
    tick();
    check("grace10_state", state_o, 1);
    check("grace10_dead",  player_dead, 0);
    set_char(500, 100, 1'b0);

    // ---- Stomp in ALIVE ----------------------------------------------------
    set_char(104, 352, 1'b1);
    tick();
    check("stomp_state",  state_o, 2);
    check("stomp_bounce", bounce_req, 1);
    check("stomp_count",  stomp_count, 1);
    check("stomp_alive",  enemy_alive, 0);
    check("stomp_squash", enemy_squash, 1);
    set_char(500, 100, 1'b0);
    tick();
    check("bounce_pulse_end", bounce_req, 0);
    ticks(3);
    check("squash4_state", state_o, 2);
    tick();
    check("gone_state",   state_o, 3);
    check("gone_visible", enemy_visible, 0);
    ticks(29);
    check("gone29_state", state_o, 3);
    tick();
    check("respawn_state", state_o, 0);
    check("respawn_count", stomp_count, 1);

    // ---- Wrap, edge contact and enable masking in ALIVE --------------------
    ticks(10);
    check("alive2_state", state_o, 1);
    enemy_x = 10'd1020;
    set_char(5, 366, 1'b0);
    tick();
    check("wrap_dead", player_dead, 0);
    enemy_x = 10'd100;
    set_char(88, 366, 1'b0);
    tick();
    check("edge88_dead", player_dead, 0);
    enemy_en = 1'b0;
    set_char(90, 366, 1'b0);
    tick();
    check("en0_side_dead", player_dead, 0);
    set_char(104, 352, 1'b1);
    tick();
    check("en0_stomp_bounce", bounce_req, 0);
    check("en0_stomp_count",  stomp_count, 1);
    check("en0_state",        state_o, 1);
    enemy_en = 1'b1;

    // ---- Stomp at exactly the margin (354+16 = 366+4) ----------------------
    set_char(104, 354, 1'b1);
    tick();
    check("margin_stomp_state", state_o, 2);
    check("margin_stomp_bounce", bounce_req, 1);
    check("margin_stomp_count", stomp_count, 2);
    set_char(500, 100, 1'b0);

    // ---- Asynchronous reset in the middle of SQUASH ------------------------
    ticks(2);
    check("squash_mid_state", state_o, 2);
    #10;
    RST_N = 1'b0;
    #1;
    check("async_rst_state", state_o, 0);
    check("async_rst_count", stomp_count, 0);
    #5;
    RST_N = 1'b1;
    tick();

    // ---- One pixel past the margin is a side hit ---------------------------
    ticks(9);
    check("alive3_state", state_o, 1);
    set_char(104, 355, 1'b1);
    tick();
    check("margin_side_dead",   player_dead, 1);
    check("margin_side_state",  state_o, 1);
    check("margin_side_bounce", bounce_req, 0);
    set_char(104, 352, 1'b1);
    tick();
    check("dead_stomp_bounce", bounce_req, 0);
    check("dead_stomp_count",  stomp_count, 0);
    check("dead_stomp_state",  state_o, 1);
    set_char(500, 100, 1'b0);

    // ---- A one-pixel overlap at the left edge kills the player -------------
    do_reset();
    check("rst2_dead", player_dead, 0);
    ticks(10);
    check("alive4_state", state_o, 1);
    set_char(89, 366, 1'b0);
    tick();
    check("edge89_dead",  player_dead, 1);
    check("edge89_state", state_o, 1);
    set_char(500, 100, 1'b0);

    // ---- Saturation: keep stomping (1 + 5 + 30 = 36 ticks per cycle) -------
    set_char(104, 352, 1'b1);
    do_reset();
    tick();
    check("sat_first_count", stomp_count, 1);
    ticks(36 * 253);
    check("sat_254_count", stomp_count, 254);
    ticks(36);
    check("sat_255_count", stomp_count, 255);
    bounces = 0;
    for (int i = 0; i < 72; i++) begin
      tick();
      if (bounce_req === 1'b1) bounces++;
    end
    check("sat_hold_count", stomp_count, 255);
    check("sat_bounces",    bounces, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/enemy_hit_ctrl.md
Name: enemy_hit_ctrl

Overview:
- Consumes one enemy's screen position and enable, plus the player's position and falling flag. Runs every 10 Hz game tick.
- Classifies each player/enemy contact as a stomp (enemy squashed, player bounces) or a side hit (player death).
- Sequences the enemy life cycle: spawn grace, alive, squash, gone, respawn. Sits directly downstream of the enemy movement block and upstream of the renderer and player physics.

Parameters:
- CHAR_W, 12, player hitbox width in pixels
- CHAR_H, 16, player hitbox height in pixels
- ENEMY_W, 12, enemy hitbox width
- ENEMY_H, 12, enemy hitbox height
- STOMP_MARGIN, 4, max depth in pixels of player feet below enemy top that still counts as a stomp
- GRACE_TICKS, 10, ticks after spawn during which side hits are ignored
- SQUASH_TICKS, 5, ticks the squashed sprite is shown
- RESPAWN_TICKS, 30, ticks in GONE before respawn; 0 = never respawn

Ports:
- clk_10Hz  in  1  game tick clock
- RST_N  in  1  asynchronous active-low reset
- char_X  in  10  player left edge, screen coords
- char_Y  in  10  player top edge, screen coords
- char_falling  in  1  player vertical velocity is downward
- enemy_x  in  10  enemy left edge, screen coords (may wrap when offscreen)
- enemy_y  in  10  enemy top edge
- enemy_en  in  1  enemy active; contact detection is disabled when low
- enemy_alive  out  1  enemy is in GRACE or ALIVE
- enemy_visible  out  1  enemy is in GRACE, ALIVE or SQUASH
- enemy_squash  out  1  enemy is in SQUASH; renderer selects the flat sprite
- bounce_req  out  1  one-tick pulse on a stomp
- player_dead  out  1  sticky flag, set on a side hit
- stomp_count  out  8  saturating stomp counter
- state_o  out  2  FSM state: GRACE=0, ALIVE=1, SQUASH=2, GONE=3

Behaviour:
- Reset (async, RST_N low):
  - state=GRACE, tick counter=0, player_dead=0, bounce_req=0, stomp_count=0.
  - Hence enemy_alive=1, enemy_visible=1, enemy_squash=0.
  - Reset mid-operation (any state) returns to this condition immediately.
- Arithmetic: all geometry comparisons use 11-bit zero-extended operands, so the +W/+H sums never wrap.
- overlap is true when all four hold:
  - char_X+CHAR_W > enemy_x
  - enemy_x+ENEMY_W > char_X
  - char_Y+CHAR_H > enemy_y
  - enemy_y+ENEMY_H > char_Y
- Edge contact (strict equality) is not an overlap.
- stomp = overlap & char_falling & (char_Y+CHAR_H <= enemy_y+STOMP_MARGIN).
- side = overlap & ~stomp. Stomp has priority, and the two are mutually exclusive by construction.
- Contact is evaluated only when enemy_en=1, the state is GRACE or ALIVE, and player_dead=0.
- All outputs are registered. A contact sampled at tick edge N is reflected after edge N.
- GRACE:
  - Counter increments each tick.
  - A stomp goes to SQUASH.
  - A side hit is ignored.
  - When counter==GRACE_TICKS-1 (with no stomp), go to ALIVE and clear the counter.
- ALIVE:
  - A stomp goes to SQUASH and clears the counter.
  - A side hit sets player_dead=1; state stays ALIVE.
- On every stomp, in GRACE or ALIVE:
  - bounce_req=1 for exactly one tick.
  - stomp_count increments, saturating at 255.
- SQUASH: counter increments; when counter==SQUASH_TICKS-1, go to GONE and clear the counter.
- GONE:
  - If RESPAWN_TICKS=0, stay in GONE until reset.
  - Otherwise, when counter==RESPAWN_TICKS-1, go to GRACE and clear the counter.
- player_dead:
  - Sticky until reset.
  - Once set, no further stomps or side hits are registered.
  - State timers continue running.
- enemy_en low:
  - Contact detection is masked.
  - The FSM and timers continue running.
- Counter is 8 bits wide; all TICKS parameters must be ≤255 (enforced by elaboration assert).

Test Plan:
- Stomp: reset, wait 10 ticks (state_o=1), enemy=(100,366), char=(104,352), char_falling=1 for one tick.
  - Required: state_o=2, bounce_req=1 for exactly one tick, stomp_count=1.
  - 5 ticks later: state_o=3, enemy_visible=0.
  - 30 ticks after that: state_o=0.
- Side hit: in ALIVE, enemy=(100,366), char=(90,366), char_falling=0 → player_dead=1, state_o stays 1. A later stomp geometry gives no bounce_req and stomp_count is unchanged.
- Edge boundary: char=(88,366) with enemy=(100,366) (88+12=100) → no overlap, player_dead=0. char=(89,366) → player_dead=1.
- Stomp margin: falling with char_Y=354 (354+16=370=366+4) → stomp. char_Y=355 → side hit, player_dead=1.
- Grace and reset:
  - Side-hit geometry during ticks 0–9 after reset → player_dead stays 0.
  - Assert RST_N low mid-SQUASH (tick 2) → state_o=0, stomp_count=0 immediately, without waiting for a clock edge.
- Wrap and enable:
  - enemy_x=1020, char_X=5, same Y → no overlap (11-bit compare).
  - enemy_en=0 with full overlap → no flag changes.
  - 256 stomps (with respawn) → stomp_count holds at 255.
